// File: rtl/q_eng_dispatch.sv
// q_eng_dispatch: front-end command dispatcher for the engine array.
// Accepts one command per cycle on a valid/ready input and issues it to a
// free engine chosen round-robin, tracking per-engine busy state from the
// engines' completion pulses. A completion frees its engine in the same
// cycle, so that engine can be re-granted without a bubble.
module q_eng_dispatch #(
  parameter int ENGINES_N = 4,
  parameter int CMD_W     = 32,
  parameter int ID_W      = $clog2(ENGINES_N),
  parameter int CNT_W     = $clog2(ENGINES_N + 1)
) (
  input  logic                 clk,
  input  logic                 srst,
  input  logic                 en_i,
  input  logic                 cmd_vld_i,
  input  logic [CMD_W-1:0]     cmd_data_i,
  output logic                 cmd_rdy_o,
  output logic [ENGINES_N-1:0] eng_req_vld_o,
  output logic [CMD_W-1:0]     eng_req_data_o,
  output logic [ID_W-1:0]      eng_req_id_o,
  input  logic [ENGINES_N-1:0] eng_done_i,
  output logic [CNT_W-1:0]     inflight_o,
  output logic                 idle_o,
  output logic                 err_o
);

  logic [ENGINES_N-1:0] busy_r;
  logic [ID_W-1:0]      rr_ptr_r;
  logic                 err_r;

  logic [ENGINES_N-1:0] free;
  logic [ENGINES_N-1:0] free_rot;
  logic [ID_W-1:0]      grant_off;
  logic [ID_W:0]        grant_sum;
  logic [ID_W-1:0]      grant_id;
  logic [ENGINES_N-1:0] grant_onehot;
  logic                 accept;
  logic [ENGINES_N-1:0] spurious_done;

  // A completing engine is grantable in the same cycle (done bypass).
  assign free      = ~busy_r | eng_done_i;
  assign cmd_rdy_o = en_i & (|free) & ~srst;
  assign accept    = cmd_vld_i & cmd_rdy_o;

  // Rotate the free vector so bit 0 is the round-robin preferred engine.
  assign free_rot = ENGINES_N'({free, free} >> rr_ptr_r);

  // Pick the lowest set bit of the rotated vector, then undo the rotation.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    grant_off = '0;
    for (int i = ENGINES_N - 1; i >= 0; i--) begin
      if (free_rot[i]) grant_off = ID_W'(i);
    end
    grant_sum = {1'b0, rr_ptr_r} + {1'b0, grant_off};
    if (grant_sum >= (ID_W + 1)'(ENGINES_N)) grant_id = ID_W'(grant_sum - (ID_W + 1)'(ENGINES_N));
    else                                     grant_id = ID_W'(grant_sum);
  end

  assign grant_onehot  = accept ? (ENGINES_N'(1) << grant_id) : '0;
  // A done for an engine that is neither busy nor being granted this cycle.
  assign spurious_done = eng_done_i & ~busy_r & ~grant_onehot;

  // Busy bitmap, round-robin pointer, issue register and sticky error.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (srst) begin
      busy_r         <= '0;
      rr_ptr_r       <= '0;
      eng_req_vld_o  <= '0;
      eng_req_data_o <= '0;
      eng_req_id_o   <= '0;
      err_r          <= 1'b0;
    end else begin
      busy_r        <= (busy_r & ~eng_done_i) | grant_onehot;
      eng_req_vld_o <= grant_onehot;
      if (accept) begin
        rr_ptr_r       <= (grant_id == ID_W'(ENGINES_N - 1)) ? '0 : grant_id + 1'b1;
        eng_req_data_o <= cmd_data_i;
        eng_req_id_o   <= grant_id;
      end
      if (|spurious_done) err_r <= 1'b1;
    end
  end

  // Occupancy is the popcount of the registered busy bitmap.
  always_comb begin
    inflight_o = '0;
    for (int i = 0; i < ENGINES_N; i++) begin
      inflight_o = inflight_o + CNT_W'(busy_r[i]);
    end
  end

  assign idle_o = (busy_r == '0) & ~(|eng_req_vld_o);
  assign err_o  = err_r;

  a_issue_onehot0 : assert property (@(posedge clk) disable iff (srst)
    $onehot0(eng_req_vld_o));
  a_no_busy_grant : assert property (@(posedge clk) disable iff (srst)
    (grant_onehot & busy_r & ~eng_done_i) == '0);
  a_no_rdy_in_rst : assert property (@(posedge clk)
    srst |-> !cmd_rdy_o);

endmodule

// File: tb/tb_q_eng_dispatch.sv
// Self-checking bench for q_eng_dispatch: a directed walk through the main
// scenarios followed by randomized traffic, all compared every cycle against
// a behavioural model of the dispatcher kept in this file.
module tb_q_eng_dispatch;

  localparam int N     = 4;
  localparam int CMD_W = 32;
  localparam int ID_W  = $clog2(N);
  localparam int CNT_W = $clog2(N + 1);

  logic             clk = 1'b0;
  logic             srst;
  logic             en_i;
  logic             cmd_vld_i;
  logic [CMD_W-1:0] cmd_data_i;
  logic             cmd_rdy_o;
  logic [N-1:0]     eng_req_vld_o;
  logic [CMD_W-1:0] eng_req_data_o;
  logic [ID_W-1:0]  eng_req_id_o;
  logic [N-1:0]     eng_done_i;
  logic [CNT_W-1:0] inflight_o;
  logic             idle_o;
  logic             err_o;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model state (what the outputs should show after the last edge).
  bit [N-1:0]       m_busy;
  int               m_rr;
  bit [N-1:0]       m_vld;
  logic [CMD_W-1:0] m_data;
  int               m_id;
  bit               m_err;
  bit               m_last_accept;

  q_eng_dispatch #(.ENGINES_N(N), .CMD_W(CMD_W)) dut (
    .clk           (clk),
    .srst          (srst),
    .en_i          (en_i),
    .cmd_vld_i     (cmd_vld_i),
    .cmd_data_i    (cmd_data_i),
    .cmd_rdy_o     (cmd_rdy_o),
    .eng_req_vld_o (eng_req_vld_o),
    .eng_req_data_o(eng_req_data_o),
    .eng_req_id_o  (eng_req_id_o),
    .eng_done_i    (eng_done_i),
    .inflight_o    (inflight_o),
    .idle_o        (idle_o),
    .err_o         (err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs just after an edge, compare at mid-cycle,
  // advance the model, then step past the next edge.
  task automatic cycle(input bit rst, input bit en, input bit vld,
                       input logic [CMD_W-1:0] data, input logic [N-1:0] done);
    bit [N-1:0] free;
    bit         rdy;
    int         e;
    srst       = rst;
    en_i       = en;
    cmd_vld_i  = vld;
    cmd_data_i = data;
    eng_done_i = done;
    #4;
    free = ~m_busy | done;
    rdy  = en && (free != 0) && !rst;
    check("cmd_rdy", cmd_rdy_o, rdy);
    check("req_vld", eng_req_vld_o, m_vld);
    check("req_data", eng_req_data_o, m_data);
    check("req_id", eng_req_id_o, m_id);
    check("inflight", inflight_o, $countones(m_busy));
    check("idle", idle_o, (m_busy == 0) && (m_vld == 0));
    check("err", err_o, m_err);

    // Round-robin choice: first free engine at or after the pointer, wrapping.
    e = -1;
    for (int k = 0; k < N; k++) begin
      if (e < 0 && free[(m_rr + k) % N]) e = (m_rr + k) % N;
    end
    m_last_accept = vld && rdy;
    if (rst) begin
      m_busy = '0; m_rr = 0; m_vld = '0; m_data = '0; m_id = 0; m_err = 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (done[i] && !m_busy[i] && !(m_last_accept && e == i)) m_err = 1;
        if (done[i]) m_busy[i] = 0;
      end
      m_vld = '0;
      if (m_last_accept) begin
        m_busy[e] = 1;
        m_vld[e]  = 1;
        m_data    = data;
        m_id      = e;
        m_rr      = (e + 1) % N;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [CMD_W-1:0] src_data;
    bit               src_vld;
    logic [N-1:0]     done;
    bit               en;

    m_busy = '0; m_rr = 0; m_vld = '0; m_data = '0; m_id = 0; m_err = 0;
    m_last_accept = 0;
    srst = 1'b1; en_i = 1'b0; cmd_vld_i = 1'b0; cmd_data_i = '0; eng_done_i = '0;
    @(posedge clk);
    #1;
    cycle(1, 0, 0, '0, '0);
    check("rst_inflight", inflight_o, 0);
    check("rst_idle", idle_o, 1);

    // Fill all four engines with 0xA0..0xA3 back to back.
    for (int k = 0; k < 4; k++) begin
      cycle(0, 1, 1, 32'hA0 + k, '0);
      check($sformatf("fill%0d_id", k), eng_req_id_o, k);
      check($sformatf("fill%0d_data", k), eng_req_data_o, 32'hA0 + k);
    end
    // 0xA4 stalls while full.
    cycle(0, 1, 1, 32'hA4, '0);
    check("full_inflight", inflight_o, 4);
    check("full_no_issue", eng_req_vld_o, 0);
    cycle(0, 1, 1, 32'hA4, '0);
    // Done on engine 2 with 0xA4 waiting: bypass grant to engine 2.
    cycle(0, 1, 1, 32'hA4, 4'b0100);
    check("bypass_vld", eng_req_vld_o, 4'b0100);
    check("bypass_data", eng_req_data_o, 32'hA4);
    check("bypass_inflight", inflight_o, 4);

    // Free engines 0 and 3 with the pointer at 3: next goes to 3, then 0.
    cycle(0, 1, 0, '0, 4'b1001);
    cycle(0, 1, 1, 32'hB0, '0);
    check("wrap_id3", eng_req_id_o, 3);
    cycle(0, 1, 1, 32'hB1, '0);
    check("wrap_id0", eng_req_id_o, 0);

    // Legit done on engine 1, then a spurious one.
    cycle(0, 1, 0, '0, 4'b0010);
    cycle(0, 1, 0, '0, 4'b0010);
    check("spur_err", err_o, 1);
    check("spur_inflight", inflight_o, 3);
    cycle(0, 1, 0, '0, '0);
    check("spur_sticky", err_o, 1);

    // Dispatch disabled: nothing accepted, completions still land.
    cycle(0, 0, 1, 32'hE0, 4'b0001);
    check("dis_inflight", inflight_o, 2);
    check("dis_no_issue", eng_req_vld_o, 0);

    // Three busy with an issue pending, then reset.
    cycle(0, 1, 1, 32'hC0, '0);
    check("pre_rst_id", eng_req_id_o, 1);
    cycle(1, 1, 0, '0, '0);
    check("post_rst_vld", eng_req_vld_o, 0);
    check("post_rst_inflight", inflight_o, 0);
    check("post_rst_idle", idle_o, 1);
    check("post_rst_err", err_o, 0);
    cycle(0, 1, 1, 32'hD0, '0);
    check("post_rst_id", eng_req_id_o, 0);

    // Randomized traffic; the source holds its command until accepted and the
    // engine model only completes work it was given (rarely a stray done).
    src_vld = 0;
    src_data = '0;
    for (int c = 0; c < 600; c++) begin
      if (!src_vld && $urandom_range(0, 2) != 0) begin
        src_vld  = 1;
        src_data = $urandom;
      end
      en = ($urandom_range(0, 7) != 0);
      done = '0;
      for (int i = 0; i < N; i++) begin
        if (m_busy[i] && $urandom_range(0, 3) == 0) done[i] = 1'b1;
        if (!m_busy[i] && $urandom_range(0, 199) == 0) done[i] = 1'b1;
      end
      if ($urandom_range(0, 149) == 0) cycle(1, en, src_vld, src_data, done);
      else                             cycle(0, en, src_vld, src_data, done);
      if (m_last_accept) src_vld = 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
